neuron_layer_sched: RTL and testbench
=====================================

Name: neuron_layer_sched

Overview:
- Sequencer that evaluates one 3-neuron, 4-input layer of the accelerator on a single shared multiply-accumulate unit.
- Input vector is accepted with a valid/ready handshake. The 12 weight×input products plus the biases are computed serially. Results are presented as Y1..Y3 with a valid_out/ready_out handshake.
- Weights and biases are held in a configuration register file that software writes while the block is idle.

Parameters:
- SHIFT, 8, arithmetic right shift applied to the accumulator before clamping
- XMIN, -127, lower clamp bound (12-bit signed)
- XMAX, 127, upper clamp bound (12-bit signed)
- ACC_W, 20, accumulator width (signed)

Ports:
- clk  in  1  clock, all state on rising edge
- arst  in  1  reset, synchronous, active-high
- X1..X4  in  8 each  signed input vector
- valid  in  1  input vector valid
- ready  out  1  block can accept an input vector
- Y1, Y2, Y3  out  8 each  signed neuron results
- valid_out  out  1  Y1..Y3 valid
- ready_out  in  1  downstream accepts results
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  5  {neuron[1:0], idx[2:0]}; idx 0..3 = w1..w4, idx 4 = bias
- cfg_data  in  16  write data; weights use bits [7:0], bias uses [15:0]
- cfg_err  out  1  one-cycle pulse when a write is rejected

Behaviour:
- Reset (arst=1 at a clock edge): state=IDLE; ready=0 during reset and 1 on the first cycle after it; valid_out=0; Y1..Y3=0; cfg_err=0; all weights and biases=0; accumulator and counters=0. Reset mid-computation aborts and discards the vector.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - ready=1.
  - On valid&&ready: latch X1..X4, clear neuron counter n=0 and input counter i=0, go to MAC.
- MAC (exactly 12 cycles): ready=0.
  - Each cycle: prod = w[n][i] × x[i], signed 16-bit.
  - When i=0: acc = sext(bias[n]) + sext(prod). Otherwise: acc = acc + sext(prod).
  - When i=3: the final sum is scaled, clamped and stored into Y(n+1); then i wraps to 0 and n increments.
  - When n=2 and i=3: go to OUT.
- Scaling and clamp:
  - s = acc >>> SHIFT, arithmetic shift.
  - y = XMIN if s<XMIN; XMAX if s>XMAX; else s. Y takes the low 8 bits.
  - Accumulator cannot overflow: |max| = 4·128·128 + 32768 = 98304, which fits in an 18-bit signed value; ACC_W ≥ 18 is required.
- OUT:
  - valid_out=1; Y1..Y3 stable.
  - On ready_out=1: go to IDLE next cycle, and valid_out drops that cycle.
  - ready_out is don't-care outside OUT.
- Latency: handshake accepted at edge T; valid_out is high from edge T+13.
  - Throughput is one vector per ≥14 cycles.
  - No overlap: ready stays 0 in MAC and OUT.
- Y1..Y3 hold their last values after OUT until overwritten in the next MAC pass. Y(n) updates during MAC, so it is valid only while valid_out=1.
- Configuration writes:
  - Accepted only in IDLE, and only when valid&&ready is not occurring in the same cycle.
  - Otherwise the write is dropped and cfg_err pulses for 1 cycle.
  - Unmapped addresses (neuron=3 or idx≥5) are dropped silently, with no error.
- Simultaneous cfg write and input handshake in IDLE: the handshake wins, the write is rejected, and cfg_err pulses. The computation uses the old weights.

Decomposition:
- Shared package/include nn_acc_pkg:
  - state encoding (IDLE/MAC/OUT)
  - data/weight/bias/accumulator widths
  - config address map constants (IDX_W1..IDX_W4, IDX_BIAS)
  - default XMIN/XMAX/SHIFT
- One sub-module nn_mac_unit, combinational:
  - inputs: w, x, acc_in, bias, first flag
  - output: acc_out
  - also instantiates the scale/clamp function.
- FSM, counters, config register file and output registers stay in neuron_layer_sched.

Test Plan:
- Reset then idle: after arst pulse, ready=1, valid_out=0, Y1..Y3=0; a read-back pass with all-zero config and X=(5,5,5,5) gives Y=(0,0,0) at T+13.
- Nominal: N1 w=(-115,1,-105,16), bias=12571; X=(10,20,30,40) -> acc=8931, Y1=34 at T+13; other neurons at zero config give 0.
- Positive saturation: N2 w=(127,127,127,127), bias=32767; X=(127,127,127,127) -> acc=97283, s=380, Y2=127.
- Negative saturation: N3 w all -128 (cfg_data 0x0080), bias=-32768; X all 127 -> s=-382, Y3=-127.
- Backpressure: hold ready_out=0 for 20 cycles in OUT -> valid_out and Y stable, ready=0; raise ready_out -> ready=1 the next cycle.
- Config protection: cfg_we during MAC, and cfg_we coincident with the input handshake -> cfg_err pulses 1 cycle, the weight is unchanged, and the result matches the old weights. arst asserted mid-MAC -> IDLE, outputs zero, no valid_out.

Source files
------------

// File: rtl/nn_acc_pkg.sv
// Shared types and constants for the layer sequencer: state encoding, datapath
// widths, config address map and the scale/clamp helper.
package nn_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam int DATA_W = 8;
  localparam int WGT_W  = 8;
  localparam int BIAS_W = 16;
  localparam int PROD_W = 16;
  localparam int ACC_W_DEF = 20;

  localparam int N_NEURON = 3;
  localparam int N_INPUT  = 4;

  localparam logic [2:0] IDX_W1   = 3'd0;
  localparam logic [2:0] IDX_W2   = 3'd1;
  localparam logic [2:0] IDX_W3   = 3'd2;
  localparam logic [2:0] IDX_W4   = 3'd3;
  localparam logic [2:0] IDX_BIAS = 3'd4;

  localparam int SHIFT_DEF = 8;
  localparam int XMIN_DEF  = -127;
  localparam int XMAX_DEF  = 127;

  // Arithmetic shift then clamp; only the low byte survives to the output.
  function automatic logic signed [DATA_W-1:0] scale_clamp(
    input logic signed [31:0] acc,
    input int                 shift,
    input int                 lo,
    input int                 hi
  );
    logic signed [31:0] s;
    logic signed [31:0] r;
    s = acc >>> shift;
    if (s < lo)      r = lo;
    else if (s > hi) r = hi;
    else             r = s;
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Combinational multiply-accumulate step for one weight/input pair, plus the
// scaled and clamped view of the new accumulator value.
module nn_mac_unit
  import nn_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int XMIN  = XMIN_DEF,
  parameter int XMAX  = XMAX_DEF
) (
  input  logic signed [WGT_W-1:0]  w,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [ACC_W-1:0]  acc_in,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic                     first,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic signed [DATA_W-1:0] y
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;

  always_comb begin
    prod    = PROD_W'(w) * PROD_W'(x);
    base    = first ? ACC_W'(bias) : acc_in;
    acc_out = base + ACC_W'(prod);
    y       = scale_clamp(32'(acc_out), SHIFT, XMIN, XMAX);
  end

endmodule

// File: rtl/neuron_layer_sched.sv
// Evaluates a 3-neuron, 4-input layer serially on one shared MAC, with a
// software-written weight/bias register file that is locked while busy.
//
// state   | meaning
// IDLE    | ready=1, accepts an input vector or config writes
// MAC     | 12 cycles, one product per cycle, Y(n) written as each neuron ends
// OUT     | valid_out raised a cycle after entry, held until ready_out
module neuron_layer_sched
  import nn_acc_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF,
  parameter int XMIN  = XMIN_DEF,
  parameter int XMAX  = XMAX_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic signed [DATA_W-1:0] X1,
  input  logic signed [DATA_W-1:0] X2,
  input  logic signed [DATA_W-1:0] X3,
  input  logic signed [DATA_W-1:0] X4,
  input  logic                     valid,
  output logic                     ready,
  output logic signed [DATA_W-1:0] Y1,
  output logic signed [DATA_W-1:0] Y2,
  output logic signed [DATA_W-1:0] Y3,
  output logic                     valid_out,
  input  logic                     ready_out,
  input  logic                     cfg_we,
  input  logic [4:0]               cfg_addr,
  input  logic [15:0]              cfg_data,
  output logic                     cfg_err
);

  state_t state;
  logic [1:0] n;
  logic [1:0] i;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [DATA_W-1:0] y_nxt;
  logic signed [DATA_W-1:0] x_r [N_INPUT];
  logic signed [WGT_W-1:0]  w_r [N_NEURON][N_INPUT];
  logic signed [BIAS_W-1:0] b_r [N_NEURON];
  logic signed [DATA_W-1:0] y_r [N_NEURON];

  logic [1:0] cfg_n;
  logic [2:0] cfg_idx;
  logic       cfg_mapped;
  logic       hs;
  logic       cfg_ok;

  assign cfg_n      = cfg_addr[4:3];
  assign cfg_idx    = cfg_addr[2:0];
  assign cfg_mapped = (cfg_n != 2'd3) && (cfg_idx <= IDX_BIAS);
  assign hs         = valid && ready && (state == ST_IDLE);
  // The input handshake takes priority over a same-cycle config write.
  assign cfg_ok     = (state == ST_IDLE) && !(valid && ready);

  nn_mac_unit #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .XMIN  (XMIN),
    .XMAX  (XMAX)
  ) u_mac (
    .w       (w_r[n][i]),
    .x       (x_r[i]),
    .acc_in  (acc),
    .bias    (b_r[n]),
    .first   (i == 2'd0),
    .acc_out (acc_nxt),
    .y       (y_nxt)
  );

  always_ff @(posedge clk) begin
    if (arst) begin
      state     <= ST_IDLE;
      n         <= '0;
      i         <= '0;
      acc       <= '0;
      ready     <= 1'b0;
      valid_out <= 1'b0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < N_INPUT; k++) x_r[k] <= '0;
      for (int m = 0; m < N_NEURON; m++) begin
        b_r[m] <= '0;
        y_r[m] <= '0;
        for (int k = 0; k < N_INPUT; k++) w_r[m][k] <= '0;
      end
    end else begin
      cfg_err <= cfg_we && cfg_mapped && !cfg_ok;
      if (cfg_we && cfg_mapped && cfg_ok) begin
        if (cfg_idx == IDX_BIAS) b_r[cfg_n] <= cfg_data;
        else                     w_r[cfg_n][cfg_idx[1:0]] <= cfg_data[WGT_W-1:0];
      end

      case (state)
        ST_IDLE: begin
          ready <= 1'b1;
          if (hs) begin
            x_r[0] <= X1;
            x_r[1] <= X2;
            x_r[2] <= X3;
            x_r[3] <= X4;
            n      <= '0;
            i      <= '0;
            ready  <= 1'b0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc_nxt;
          i   <= i + 2'd1;
          if (i == 2'd3) begin
            y_r[n] <= y_nxt;
            n      <= n + 2'd1;
            if (n == 2'd2) state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (!valid_out) begin
            valid_out <= 1'b1;
          end else if (ready_out) begin
            valid_out <= 1'b0;
            ready     <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Y1 = y_r[0];
  assign Y2 = y_r[1];
  assign Y3 = y_r[2];

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Randomized and directed bench for neuron_layer_sched against a plain
// arithmetic model of the layer and its config register file.
module tb_neuron_layer_sched;

  logic clk = 1'b0;
  logic arst;
  logic signed [7:0] X1, X2, X3, X4;
  logic valid;
  logic ready;
  logic signed [7:0] Y1, Y2, Y3;
  logic valid_out;
  logic ready_out;
  logic cfg_we;
  logic [4:0] cfg_addr;
  logic [15:0] cfg_data;
  logic cfg_err;

  int total = 0;
  int bad = 0;

  int mw [3][4];
  int mb [3];
  int xm [4];

  always #5 clk = ~clk;

  neuron_layer_sched dut (
    .clk       (clk),
    .arst      (arst),
    .X1        (X1),
    .X2        (X2),
    .X3        (X3),
    .X4        (X4),
    .valid     (valid),
    .ready     (ready),
    .Y1        (Y1),
    .Y2        (Y2),
    .Y3        (Y3),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_y(input int nn);
    int acc;
    int s;
    acc = mb[nn];
    for (int k = 0; k < 4; k++) acc += mw[nn][k] * xm[k];
    s = acc >>> 8;
    if (s < -127) s = -127;
    else if (s > 127) s = 127;
    return s;
  endfunction

  function automatic void model_clear();
    for (int m = 0; m < 3; m++) begin
      mb[m] = 0;
      for (int k = 0; k < 4; k++) mw[m][k] = 0;
    end
  endfunction

  task automatic do_reset();
    arst = 1'b1;
    tick();
    tick();
    chk("ready_in_reset", ready, 0);
    arst = 1'b0;
    model_clear();
    tick();
    chk("ready_after_reset", ready, 1);
    chk("vo_after_reset", valid_out, 0);
    chk("y1_after_reset", int'(Y1), 0);
    chk("y2_after_reset", int'(Y2), 0);
    chk("y3_after_reset", int'(Y3), 0);
    chk("err_after_reset", cfg_err, 0);
  endtask

  task automatic cfg_write(input int nn, input int idx, input logic [15:0] d);
    cfg_addr = {nn[1:0], idx[2:0]};
    cfg_data = d;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    chk("cfg_err_idle", cfg_err, 0);
    if (nn < 3 && idx < 5) begin
      if (idx == 4) mb[nn] = int'($signed(d));
      else          mw[nn][idx] = int'($signed(d[7:0]));
    end
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 40) begin
      tick();
      k++;
    end
    if (!ready) chk("ready_timeout", ready, 1);
  endtask

  task automatic run_vec(input int hold, input bit coinc, input bit busy_wr);
    int e1, e2, e3;
    int k;
    wait_ready();
    e1 = ref_y(0);
    e2 = ref_y(1);
    e3 = ref_y(2);
    X1 = 8'(xm[0]);
    X2 = 8'(xm[1]);
    X3 = 8'(xm[2]);
    X4 = 8'(xm[3]);
    valid = 1'b1;
    if (coinc) begin
      cfg_addr = {2'd0, 3'd0};
      cfg_data = 16'((mw[0][0] + 1) & 255);
      cfg_we   = 1'b1;
    end
    tick();
    valid  = 1'b0;
    cfg_we = 1'b0;
    if (coinc) chk("cfg_err_coinc", cfg_err, 1);
    chk("ready_busy", ready, 0);
    if (busy_wr) begin
      cfg_addr = {2'd1, 3'd2};
      cfg_data = 16'((mw[1][2] + 3) & 255);
    end
    k = 0;
    while (!valid_out && k < 40) begin
      cfg_we = busy_wr && (k == 3);
      ready_out = 1'($urandom_range(0, 1));
      tick();
      k++;
      if (busy_wr && k == 4) chk("cfg_err_busy", cfg_err, 1);
      if (busy_wr && k == 5) chk("cfg_err_pulse", cfg_err, 0);
    end
    cfg_we = 1'b0;
    ready_out = 1'b0;
    chk("latency", k, 13);
    chk("y1", int'(Y1), e1);
    chk("y2", int'(Y2), e2);
    chk("y3", int'(Y3), e3);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_vo", valid_out, 1);
      chk("hold_ready", ready, 0);
      chk("hold_y1", int'(Y1), e1);
      chk("hold_y3", int'(Y3), e3);
    end
    ready_out = 1'b1;
    tick();
    ready_out = 1'b0;
    chk("vo_drop", valid_out, 0);
    chk("ready_back", ready, 1);
    chk("y2_kept", int'(Y2), e2);
  endtask

  initial begin
    int vo_seen;
    arst = 1'b1;
    X1 = '0; X2 = '0; X3 = '0; X4 = '0;
    valid = 1'b0;
    ready_out = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    model_clear();
    for (int k = 0; k < 4; k++) xm[k] = 0;

    do_reset();

    for (int k = 0; k < 4; k++) xm[k] = 5;
    run_vec(0, 0, 0);

    // nominal neuron 1
    cfg_write(0, 0, 16'(-115 & 255));
    cfg_write(0, 1, 16'd1);
    cfg_write(0, 2, 16'(-105 & 255));
    cfg_write(0, 3, 16'd16);
    cfg_write(0, 4, 16'd12571);
    xm[0] = 10; xm[1] = 20; xm[2] = 30; xm[3] = 40;
    run_vec(0, 0, 0);
    chk("nominal_y1", int'(Y1), 34);

    // saturation in both directions
    for (int k = 0; k < 4; k++) cfg_write(1, k, 16'd127);
    cfg_write(1, 4, 16'h7fff);
    for (int k = 0; k < 4; k++) cfg_write(2, k, 16'h0080);
    cfg_write(2, 4, 16'h8000);
    for (int k = 0; k < 4; k++) xm[k] = 127;
    run_vec(1, 0, 0);
    chk("pos_sat_y2", int'(Y2), 127);
    chk("neg_sat_y3", int'(Y3), -127);

    run_vec(20, 0, 0);

    // rejected writes keep old weights
    xm[0] = -7; xm[1] = 33; xm[2] = 90; xm[3] = -128;
    run_vec(1, 1, 0);
    run_vec(0, 0, 1);
    run_vec(0, 0, 0);

    // unmapped writes are silently ignored
    cfg_write(3, 0, 16'h1234);
    cfg_write(0, 5, 16'h00ff);
    cfg_write(1, 7, 16'h00ff);
    run_vec(0, 0, 0);

    // reset in the middle of MAC
    wait_ready();
    xm[0] = 100; xm[1] = 100; xm[2] = 100; xm[3] = 100;
    X1 = 8'(xm[0]); X2 = 8'(xm[1]); X3 = 8'(xm[2]); X4 = 8'(xm[3]);
    valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (6) tick();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    model_clear();
    chk("midrst_vo", valid_out, 0);
    chk("midrst_y1", int'(Y1), 0);
    chk("midrst_y2", int'(Y2), 0);
    tick();
    chk("midrst_ready", ready, 1);
    vo_seen = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (valid_out) vo_seen = 1;
    end
    chk("midrst_no_vo", vo_seen, 0);
    run_vec(0, 0, 0);

    // randomized config and vectors
    for (int it = 0; it < 14; it++) begin
      int nw;
      nw = $urandom_range(1, 6);
      for (int j = 0; j < nw; j++)
        cfg_write($urandom_range(0, 2), $urandom_range(0, 4), 16'($urandom_range(0, 65535)));
      for (int k = 0; k < 4; k++) xm[k] = int'($signed(8'($urandom_range(0, 255))));
      run_vec($urandom_range(0, 3), bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
